replay_buffer: RTL

REPLAY_BUFFER -- requirements
Module: replay_buffer

---
 rtl/replay_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/replay_buffer.sv
// Replay buffer: records strobed bytes into a synchronous-read RAM and, on
// request, plays them back one at a time to a downstream transmitter.
module replay_buffer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [7:0]        data,
  input  logic              record_en,
  input  logic              replay_start,
  input  logic              replay_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              replay_done
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [ADDR_W:0] rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      ram_q;
  logic            rec_fire;
  logic            full;

  assign rec_fire = ready && record_en;
  assign full     = (count == DEPTH_L);

  // Recording bookkeeping: count saturates at DEPTH, a dropped byte sets the sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (rec_fire) begin
      if (!full) count    <= count + 1'b1;
      else       overflow <= 1'b1;
    end
  end

  // RAM write port: append the received byte at the current fill level.
  // NOTE: the storage array has no reset; stale contents are never read because count restarts at 0.
  always_ff @(posedge clk) begin
    if (!rst && rec_fire && !full) mem[count[ADDR_W-1:0]] <= data;
  end

  // RAM read port: one-cycle latency, address held steady by the FSM during FETCH.
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Replay FSM: fetch, latch, launch one byte, then wait for the transmitter to drain.
  // NOTE: all state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      replay_done <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      replay_done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (replay_start) begin
            rd_ptr <= '0;
            state  <= (count == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          tx_data <= ram_q;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (replay_en && !tx_busy) begin
            tx_start <= 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= S_GUARD;
          end
        end
        // The transmitter only raises busy a cycle after tx_start, so skip one sample of it.
        S_GUARD: state <= S_WAIT;
        S_WAIT: begin
          if (!tx_busy) state <= (rd_ptr == count) ? S_DONE : S_FETCH;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
